// File: rtl/ram_write_buffer_if.sv
// ---------------------------------------------------------------------------
// ram_write_buffer_if
// Bundles the cache-side, forwarding and RAM-side signals of the write buffer.
//   slave  : seen by the buffer itself
//   master : seen by whatever drives the buffer (cache + RAM arbiter model)
// Signals:
//   in_write/in_addr/in_data -> write request, in_ready <- accepted
//   rd_req/rd_addr           -> forwarding lookup, rd_hit/rd_data <- result
//   ram_req -> arbiter, ram_grant <- arbiter
//   ram_write/ram_addr/ram_data -> RAM write port
//   count/empty/full         -> occupancy status
// ---------------------------------------------------------------------------
interface ram_write_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 14,
    parameter int DW    = 10,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic          in_write;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_hit;
    logic [DW-1:0] rd_data;
    logic          ram_req;
    logic          ram_grant;
    logic          ram_write;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    modport slave (
        input  in_write, in_addr, in_data, rd_req, rd_addr, ram_grant,
        output in_ready, rd_hit, rd_data, ram_req, ram_write, ram_addr,
               ram_data, count, empty, full
    );

    modport master (
        output in_write, in_addr, in_data, rd_req, rd_addr, ram_grant,
        input  in_ready, rd_hit, rd_data, ram_req, ram_write, ram_addr,
               ram_data, count, empty, full
    );
endinterface

// File: rtl/ram_write_buffer.sv
// ---------------------------------------------------------------------------
// ram_write_buffer
// Posted-write buffer between a cache and a shared RAM. Writes are queued in a
// circular FIFO, coalesced by address, forwarded to cache reads, and drained
// to the RAM through a request/grant arbiter handshake (IDLE -> REQ -> WRITE).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : ram_write_buffer_if.slave (write, forwarding, RAM and status signals)
// ---------------------------------------------------------------------------
module ram_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 14,
    parameter int DW    = 10
) (
    input  logic               clk,
    input  logic               rst,
    ram_write_buffer_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          full_s, accept_s, push_s, pop_s, coal_s;
    logic          wr_match_s, rd_match_s;
    logic [PW-1:0] wr_idx_s, rd_idx_s;
    logic [PW-1:0] age_idx_s [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Physical slot that is k places younger than the head.
    function automatic logic [PW-1:0] age_idx(input logic [PW-1:0] h, input int k);
        int s;
        s = int'(h) + k;
        if (s >= DEPTH) begin
            s = s - DEPTH;
        end else begin
            s = s;
        end
        return PW'(s);
    endfunction

    // Status and handshake decode.
    always_comb begin
        full_s   = (count_q == CW'(DEPTH));
        accept_s = bus.in_write && !full_s;
        pop_s    = (state_q == ST_WRITE);
    end

    // Slot order from oldest (k=0) to youngest.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_idx_s[k] = age_idx(head_q, k);
        end
    end

    // Address match search in age order; the last hit is the youngest entry.
    // The head being written this cycle is excluded from coalescing so the
    // new data is not lost when the head retires at the end of the cycle.
    always_comb begin
        wr_match_s = 1'b0;
        wr_idx_s   = '0;
        rd_match_s = 1'b0;
        rd_idx_s   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_q[age_idx_s[k]] && (addr_q[age_idx_s[k]] == bus.in_addr) &&
                !(pop_s && (age_idx_s[k] == head_q))) begin
                wr_match_s = 1'b1;
                wr_idx_s   = age_idx_s[k];
            end else begin
                wr_match_s = wr_match_s;
            end
            if (valid_q[age_idx_s[k]] && (addr_q[age_idx_s[k]] == bus.rd_addr)) begin
                rd_match_s = 1'b1;
                rd_idx_s   = age_idx_s[k];
            end else begin
                rd_match_s = rd_match_s;
            end
        end
    end

    // Pointer and occupancy next-state.
    always_comb begin
        coal_s  = accept_s && wr_match_s;
        push_s  = accept_s && !wr_match_s;
        head_d  = pop_s  ? ptr_inc(head_q) : head_q;
        tail_d  = push_s ? ptr_inc(tail_q) : tail_q;
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Drain FSM next-state; uses post-update occupancy so a write into an
    // empty buffer reaches REQ on the very next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = (count_d != '0) ? ST_REQ : ST_IDLE;
            ST_REQ:   state_d = bus.ram_grant ? ST_WRITE : ST_REQ;
            ST_WRITE: state_d = (count_d != '0) ? ST_REQ : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Drain FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffer storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // A push never targets the head being popped: that would need a
            // full buffer, where pushes are refused.
            if (pop_s) begin
                valid_q[head_q] <= 1'b0;
            end
            if (push_s) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= bus.in_addr;
                data_q[tail_q]  <= bus.in_data;
            end
            if (coal_s) begin
                data_q[wr_idx_s] <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = !full_s;
    assign bus.ram_req   = (state_q == ST_REQ);
    assign bus.ram_write = (state_q == ST_WRITE);
    assign bus.ram_addr  = valid_q[head_q] ? addr_q[head_q] : '0;
    assign bus.ram_data  = valid_q[head_q] ? data_q[head_q] : '0;
    assign bus.rd_hit    = bus.rd_req && rd_match_s;
    assign bus.rd_data   = (bus.rd_req && rd_match_s) ? data_q[rd_idx_s] : '0;
    assign bus.count     = count_q;
    assign bus.empty     = (count_q == '0);
    assign bus.full      = full_s;

endmodule

// File: tb/tb_ram_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_ram_write_buffer
// Directed self-checking bench for ram_write_buffer. Inputs are driven 2 time
// units after the rising edge and outputs sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_ram_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 14;
    localparam int DW    = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ram_write_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    ram_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.in_write  = 1'b0;
        bus.in_addr   = 14'h0000;
        bus.in_data   = 10'h000;
        bus.rd_req    = 1'b0;
        bus.rd_addr   = 14'h0000;
        bus.ram_grant = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        #1;
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", bus.empty); end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", bus.full); end
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        total++; if (bus.ram_req !== 1'b0 || bus.ram_write !== 1'b0) begin bad++; $display("FAIL reset_ram got req=%0b wr=%0b exp 0 0", bus.ram_req, bus.ram_write); end
        total++; if (bus.ram_addr !== 14'h0000 || bus.ram_data !== 10'h000) begin bad++; $display("FAIL reset_ram_bus got=%h/%h exp=0/0", bus.ram_addr, bus.ram_data); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
        bus.rd_req = 1'b1;
        #1;
        total++; if (bus.rd_hit !== 1'b0 || bus.rd_data !== 10'h000) begin bad++; $display("FAIL reset_rd got hit=%0b data=%h exp 0 0", bus.rd_hit, bus.rd_data); end
        bus.rd_req = 1'b0;
    endtask

    task automatic test_single_write();
        do_reset();
        bus.ram_grant = 1'b1;
        bus.in_write  = 1'b1;
        bus.in_addr   = 14'h0010;
        bus.in_data   = 10'h155;
        #1;
        total++; if (bus.in_ready !== 1'b1 || bus.ram_req !== 1'b0) begin bad++; $display("FAIL single_c1 got rdy=%0b req=%0b exp 1 0", bus.in_ready, bus.ram_req); end
        tick();
        bus.in_write = 1'b0;
        #1;
        total++; if (bus.ram_req !== 1'b1 || bus.ram_write !== 1'b0) begin bad++; $display("FAIL single_c2 got req=%0b wr=%0b exp 1 0", bus.ram_req, bus.ram_write); end
        tick();
        #1;
        total++; if (bus.ram_write !== 1'b1 || bus.ram_addr !== 14'h0010 || bus.ram_data !== 10'h155) begin bad++; $display("FAIL single_c3 got wr=%0b addr=%h data=%h exp 1 0010 155", bus.ram_write, bus.ram_addr, bus.ram_data); end
        tick();
        #1;
        total++; if (bus.empty !== 1'b1 || bus.ram_write !== 1'b0 || bus.ram_req !== 1'b0) begin bad++; $display("FAIL single_after got empty=%0b wr=%0b req=%0b exp 1 0 0", bus.empty, bus.ram_write, bus.ram_req); end
    endtask

    task automatic test_fill();
        logic [AW-1:0] got_a [$];
        logic [AW-1:0] exp_a;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.in_write = 1'b1;
            bus.in_addr  = 14'h0100 + AW'(i);
            bus.in_data  = 10'h001 + DW'(i);
            #1;
            total++; if (bus.in_ready !== (i < 4)) begin bad++; $display("FAIL fill_ready_%0d got=%0b exp=%0b", i, bus.in_ready, (i < 4)); end
            tick();
        end
        bus.in_write = 1'b0;
        bus.rd_req   = 1'b1;
        bus.rd_addr  = 14'h0104;
        #1;
        total++; if (bus.count !== 3'd4 || bus.full !== 1'b1 || bus.empty !== 1'b0) begin bad++; $display("FAIL fill_status got cnt=%0d full=%0b empty=%0b exp 4 1 0", bus.count, bus.full, bus.empty); end
        total++; if (bus.ram_req !== 1'b1) begin bad++; $display("FAIL fill_req_hold got=%0b exp=1", bus.ram_req); end
        total++; if (bus.rd_hit !== 1'b0) begin bad++; $display("FAIL fill_dropped_miss got=%0b exp=0", bus.rd_hit); end
        bus.rd_req    = 1'b0;
        bus.ram_grant = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.ram_write === 1'b1) got_a.push_back(bus.ram_addr);
            tick();
        end
        total++; if (got_a.size() != 4) begin bad++; $display("FAIL fill_drain_n got=%0d exp=4", got_a.size()); end
        for (int i = 0; i < got_a.size() && i < 4; i++) begin
            exp_a = 14'h0100 + AW'(i);
            total++; if (got_a[i] !== exp_a) begin bad++; $display("FAIL fill_drain_addr_%0d got=%h exp=%h", i, got_a[i], exp_a); end
        end
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL fill_drained_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_coalesce();
        logic [DW-1:0] got_d [$];
        do_reset();
        bus.in_write = 1'b1;
        bus.in_addr  = 14'h0020;
        bus.in_data  = 10'h001;
        tick();
        bus.in_data  = 10'h2AA;
        tick();
        bus.in_write = 1'b0;
        bus.rd_req   = 1'b1;
        bus.rd_addr  = 14'h0020;
        #1;
        total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL coal_count got=%0d exp=1", bus.count); end
        total++; if (bus.rd_hit !== 1'b1 || bus.rd_data !== 10'h2AA) begin bad++; $display("FAIL coal_fwd got hit=%0b data=%h exp 1 2aa", bus.rd_hit, bus.rd_data); end
        bus.rd_req    = 1'b0;
        bus.ram_grant = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.ram_write === 1'b1) got_d.push_back(bus.ram_data);
            tick();
        end
        total++; if (got_d.size() != 1) begin bad++; $display("FAIL coal_ram_n got=%0d exp=1", got_d.size()); end
        total++; if (got_d.size() > 0 && got_d[0] !== 10'h2AA) begin bad++; $display("FAIL coal_ram_data got=%h exp=2aa", got_d[0]); end
    endtask

    task automatic test_forward();
        do_reset();
        bus.in_write = 1'b1;
        bus.in_addr  = 14'h0030;
        bus.in_data  = 10'h0F0;
        tick();
        bus.in_write = 1'b0;
        bus.rd_req   = 1'b1;
        bus.rd_addr  = 14'h0030;
        #1;
        total++; if (bus.rd_hit !== 1'b1 || bus.rd_data !== 10'h0F0) begin bad++; $display("FAIL fwd_hit got hit=%0b data=%h exp 1 0f0", bus.rd_hit, bus.rd_data); end
        bus.rd_addr = 14'h0031;
        #1;
        total++; if (bus.rd_hit !== 1'b0 || bus.rd_data !== 10'h000) begin bad++; $display("FAIL fwd_miss got hit=%0b data=%h exp 0 000", bus.rd_hit, bus.rd_data); end
        bus.rd_req  = 1'b0;
        bus.rd_addr = 14'h0030;
        #1;
        total++; if (bus.rd_hit !== 1'b0) begin bad++; $display("FAIL fwd_no_req got=%0b exp=0", bus.rd_hit); end
        // Read of an address being written this same cycle must miss.
        bus.rd_req   = 1'b1;
        bus.rd_addr  = 14'h0040;
        bus.in_write = 1'b1;
        bus.in_addr  = 14'h0040;
        bus.in_data  = 10'h123;
        #1;
        total++; if (bus.rd_hit !== 1'b0) begin bad++; $display("FAIL fwd_no_bypass got=%0b exp=0", bus.rd_hit); end
        tick();
        bus.in_write = 1'b0;
        #1;
        total++; if (bus.rd_hit !== 1'b1 || bus.rd_data !== 10'h123) begin bad++; $display("FAIL fwd_next got hit=%0b data=%h exp 1 123", bus.rd_hit, bus.rd_data); end
        bus.rd_req = 1'b0;
    endtask

    task automatic test_head_in_write();
        do_reset();
        bus.in_write = 1'b1;
        bus.in_addr  = 14'h0050;
        bus.in_data  = 10'h011;
        tick();
        bus.in_write  = 1'b0;
        bus.ram_grant = 1'b1;
        tick();
        bus.ram_grant = 1'b0;
        bus.in_write  = 1'b1;
        bus.in_data   = 10'h022;
        bus.rd_req    = 1'b1;
        bus.rd_addr   = 14'h0050;
        #1;
        total++; if (bus.ram_write !== 1'b1 || bus.ram_data !== 10'h011) begin bad++; $display("FAIL hw_write got wr=%0b data=%h exp 1 011", bus.ram_write, bus.ram_data); end
        total++; if (bus.rd_hit !== 1'b1 || bus.rd_data !== 10'h011) begin bad++; $display("FAIL hw_fwd got hit=%0b data=%h exp 1 011", bus.rd_hit, bus.rd_data); end
        tick();
        idle_inputs();
        #1;
        total++; if (bus.count !== 3'd1 || bus.ram_req !== 1'b1) begin bad++; $display("FAIL hw_pushpop got cnt=%0d req=%0b exp 1 1", bus.count, bus.ram_req); end
        total++; if (bus.ram_addr !== 14'h0050 || bus.ram_data !== 10'h022) begin bad++; $display("FAIL hw_new_head got=%h/%h exp=0050/022", bus.ram_addr, bus.ram_data); end
    endtask

    task automatic test_wrap();
        int j = 0;
        int w = 0;
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_d;
        do_reset();
        for (int c = 0; c < 200 && w < 10; c++) begin
            bus.ram_grant = c[0];
            bus.in_write  = (j < 10);
            bus.in_addr   = 14'h0200 + AW'(j);
            bus.in_data   = 10'h100 + DW'(j);
            #1;
            if (bus.ram_write === 1'b1) begin
                exp_a = 14'h0200 + AW'(w);
                exp_d = 10'h100 + DW'(w);
                total++; if (bus.ram_addr !== exp_a || bus.ram_data !== exp_d) begin bad++; $display("FAIL wrap_write_%0d got=%h/%h exp=%h/%h", w, bus.ram_addr, bus.ram_data, exp_a, exp_d); end
                w++;
            end
            total++; if (bus.count > 3'd4) begin bad++; $display("FAIL wrap_count_range got=%0d exp<=4", bus.count); end
            if (bus.in_write && bus.in_ready) j++;
            tick();
        end
        bus.in_write = 1'b0;
        #1;
        total++; if (w != 10) begin bad++; $display("FAIL wrap_total got=%0d exp=10", w); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%0b exp=1", bus.empty); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.in_write = 1'b1;
            bus.in_addr  = 14'h0300 + AW'(i);
            bus.in_data  = 10'h0A0 + DW'(i);
            tick();
        end
        bus.in_write  = 1'b0;
        bus.ram_grant = 1'b1;
        tick();
        #1;
        total++; if (bus.ram_write !== 1'b1) begin bad++; $display("FAIL rmd_in_write got=%0b exp=1", bus.ram_write); end
        rst = 1'b0;
        #1;
        total++; if (bus.ram_write !== 1'b0 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL rmd_abort got wr=%0b cnt=%0d empty=%0b exp 0 0 1", bus.ram_write, bus.count, bus.empty); end
        total++; if (bus.ram_addr !== 14'h0000 || bus.ram_req !== 1'b0) begin bad++; $display("FAIL rmd_bus got addr=%h req=%0b exp 0 0", bus.ram_addr, bus.ram_req); end
        tick();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            total++; if (bus.ram_write !== 1'b0) begin bad++; $display("FAIL rmd_no_write_%0d got=%0b exp=0", c, bus.ram_write); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill();
        test_coalesce();
        test_forward();
        test_head_in_write();
        test_wrap();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
